// File: rtl/lcd_spi_tx.sv
// rtl/lcd_spi_tx.sv - memory-mapped SPI mode-0 transmitter for the Hack LCD
// Shifts one 8-bit command/data byte or 16-bit pixel word MSB-first; busy is polled via out[0].
module lcd_spi_tx #(
   parameter int CLK_DIV = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        addr,
   input  logic [15:0] in,
   output logic [15:0] out,
   output logic        lcd_dcn,
   output logic        lcd_mosi,
   output logic        lcd_sck,
   output logic        lcd_cen
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOW,
      S_HIGH,
      S_HOLD
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t      state_q;
   logic [7:0]  div_q;
   logic [3:0]  bit_q;
   logic [15:0] sh_q;
   logic        busy_q;
   logic        dcn_q;
   logic        mosi_q;
   logic        sck_q;
   logic        cen_q;
   logic        div_done;

   assign div_done = (div_q == DIV_LAST);

   // Bytes are left-justified into the shifter so both widths leave from bit 15.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         div_q   <= 8'd0;
         bit_q   <= 4'd0;
         sh_q    <= 16'd0;
         busy_q  <= 1'b0;
         dcn_q   <= 1'b1;
         mosi_q  <= 1'b0;
         sck_q   <= 1'b0;
         cen_q   <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (load) begin
                  busy_q  <= 1'b1;
                  cen_q   <= 1'b0;
                  div_q   <= 8'd0;
                  state_q <= S_LOW;
                  if (addr) begin
                     sh_q   <= in;
                     dcn_q  <= 1'b1;
                     bit_q  <= 4'd15;
                     mosi_q <= in[15];
                  end else begin
                     sh_q   <= {in[7:0], 8'h00};
                     dcn_q  <= in[8];
                     bit_q  <= 4'd7;
                     mosi_q <= in[7];
                  end
               end
            end
            S_LOW: begin
               if (div_done) begin
                  div_q   <= 8'd0;
                  sck_q   <= 1'b1;
                  state_q <= S_HIGH;
               end else begin
                  div_q <= div_q + 8'd1;
               end
            end
            S_HIGH: begin
               if (div_done) begin
                  div_q <= 8'd0;
                  sck_q <= 1'b0;
                  if (bit_q != 4'd0) begin
                     sh_q    <= sh_q << 1;
                     mosi_q  <= sh_q[14];
                     bit_q   <= bit_q - 4'd1;
                     state_q <= S_LOW;
                  end else begin
                     state_q <= S_HOLD;
                  end
               end else begin
                  div_q <= div_q + 8'd1;
               end
            end
            S_HOLD: begin
               if (div_done) begin
                  div_q   <= 8'd0;
                  cen_q   <= 1'b1;
                  mosi_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  div_q <= div_q + 8'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign out      = {15'd0, busy_q};
   assign lcd_dcn  = dcn_q;
   assign lcd_mosi = mosi_q;
   assign lcd_sck  = sck_q;
   assign lcd_cen  = cen_q;

endmodule

// File: tb/tb_lcd_spi_tx.sv
// tb/tb_lcd_spi_tx.sv - scoreboard bench for lcd_spi_tx at CLK_DIV=4 and CLK_DIV=1
module tb_lcd_spi_tx;

   logic        clk = 1'b0;
   logic        reset_a, reset_b, load_a, load_b, addr;
   logic [15:0] in;
   logic [15:0] out_a, out_b;
   logic        lcd_dcn_a, lcd_mosi_a, lcd_sck_a, lcd_cen_a;
   logic        lcd_dcn_b, lcd_mosi_b, lcd_sck_b, lcd_cen_b;

   always #5 clk = ~clk;

   lcd_spi_tx #(.CLK_DIV(4)) u_a (
      .clk(clk), .reset(reset_a), .load(load_a), .addr(addr), .in(in), .out(out_a),
      .lcd_dcn(lcd_dcn_a), .lcd_mosi(lcd_mosi_a), .lcd_sck(lcd_sck_a), .lcd_cen(lcd_cen_a)
   );

   lcd_spi_tx #(.CLK_DIV(1)) u_b (
      .clk(clk), .reset(reset_b), .load(load_b), .addr(addr), .in(in), .out(out_b),
      .lcd_dcn(lcd_dcn_b), .lcd_mosi(lcd_mosi_b), .lcd_sck(lcd_sck_b), .lcd_cen(lcd_cen_b)
   );

   // The monitor watches whichever instance sel points at.
   logic        sel = 1'b0;
   logic [15:0] m_out;
   logic        m_busy, m_dcn, m_mosi, m_sck, m_cen;
   assign m_out  = sel ? out_b : out_a;
   assign m_busy = m_out[0];
   assign m_dcn  = sel ? lcd_dcn_b : lcd_dcn_a;
   assign m_mosi = sel ? lcd_mosi_b : lcd_mosi_a;
   assign m_sck  = sel ? lcd_sck_b : lcd_sck_a;
   assign m_cen  = sel ? lcd_cen_b : lcd_cen_a;

   typedef struct {
      int          n;
      logic [15:0] bits;
      logic        dcn;
      int          cycles;
      bit          aborted;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic push(input int n, input logic [15:0] bits, input logic dcn, input int div,
                       input bit ab);
      exp_t e;
      e.n = n;
      e.bits = bits;
      e.dcn = dcn;
      e.cycles = (2 * n + 1) * div;
      e.aborted = ab;
      sb.push_back(e);
   endtask

   // Monitor: gathers one transfer per busy window, then pops and compares.
   logic        prev_busy = 1'b0, prev_sck = 1'b0, prev_cen = 1'b1;
   logic        dcn0, dcn_ok, cen_ok;
   logic [15:0] got_bits, mask;
   int          edges, cyc, edges_b = 0;
   exp_t        e_mon;

   always @(negedge clk) begin
      if (m_busy === 1'b1 && !prev_busy) begin
         edges = 0;
         cyc = 0;
         got_bits = 16'd0;
         dcn0 = m_dcn;
         dcn_ok = 1'b1;
         cen_ok = 1'b1;
         check("cen_high_before_start", {31'd0, prev_cen}, 32'd1);
      end
      if (m_busy === 1'b1) begin
         cyc++;
         if (m_sck && !prev_sck) begin
            if (edges < 16) got_bits[15 - edges] = m_mosi;
            edges++;
            if (sel) edges_b++;
         end
         if (m_dcn !== dcn0) dcn_ok = 1'b0;
         if (m_cen !== 1'b0) cen_ok = 1'b0;
      end
      if (m_busy === 1'b0 && prev_busy) begin
         if (sb.size() == 0) begin
            check("unexpected_transfer", 32'd1, 32'd0);
         end else begin
            e_mon = sb.pop_front();
            mask = 16'hFFFF << (16 - e_mon.n);
            check("sck_edges", edges, e_mon.n);
            check("mosi_bits", {16'd0, got_bits & mask}, {16'd0, e_mon.bits & mask});
            check("dcn_value", {31'd0, dcn0}, {31'd0, e_mon.dcn});
            check("dcn_stable", {31'd0, dcn_ok}, 32'd1);
            check("cen_low_in_xfer", {31'd0, cen_ok}, 32'd1);
            if (!e_mon.aborted) check("busy_cycles", cyc, e_mon.cycles);
            check("idle_pins", {13'd0, m_out, m_cen, m_sck, m_mosi},
                  {13'd0, 16'h0000, 1'b1, 1'b0, 1'b0});
         end
      end
      prev_busy = (m_busy === 1'b1);
      prev_sck  = (m_sck === 1'b1);
      prev_cen  = (m_cen !== 1'b0);
   end

   task automatic send(input bit b, input logic a, input logic [15:0] d);
      addr = a;
      in = d;
      if (b) load_b = 1'b1; else load_a = 1'b1;
      @(negedge clk);
      load_a = 1'b0;
      load_b = 1'b0;
      check("busy_latency", {31'd0, m_busy}, 32'd1);
   endtask

   task automatic wait_idle(input int bound);
      int k = 0;
      while (m_busy !== 1'b0 && k < bound) begin
         @(negedge clk);
         k++;
      end
      check("idle_timeout", {31'd0, m_busy}, 32'd0);
   endtask

   task automatic check_reset_pins_a(input string name);
      check(name, {12'd0, out_a, lcd_cen_a, lcd_sck_a, lcd_mosi_a, lcd_dcn_a},
            {12'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1});
   endtask

   initial begin
      reset_a = 1'b1;
      reset_b = 1'b1;
      load_a = 1'b0;
      load_b = 1'b0;
      addr = 1'b0;
      in = 16'd0;
      repeat (2) @(negedge clk);
      reset_a = 1'b0;
      reset_b = 1'b0;
      check_reset_pins_a("reset_state");

      push(8, 16'h2A00, 1'b0, 4, 1'b0);
      send(1'b0, 1'b0, 16'h002A);
      wait_idle(200);
      check("dcn_retained", {31'd0, lcd_dcn_a}, 32'd0);

      addr = 1'b0;
      in = 16'h00AA;
      load_a = 1'b1;
      reset_a = 1'b1;
      @(negedge clk);
      load_a = 1'b0;
      reset_a = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check_reset_pins_a("load_with_reset");
         @(negedge clk);
      end

      push(16, 16'hF800, 1'b1, 4, 1'b0);
      send(1'b0, 1'b1, 16'hF800);
      repeat (10) @(negedge clk);
      check("out_busy", {16'd0, out_a}, 32'h0001);
      send(1'b0, 1'b0, 16'h01FF);
      wait_idle(300);

      push(5, 16'h2800, 1'b0, 4, 1'b1);
      send(1'b0, 1'b0, 16'h002A);
      begin
         int rises = 0;
         int k = 0;
         logic ps = 1'b0;
         while (rises < 5 && k < 200) begin
            if (lcd_sck_a && !ps) rises++;
            ps = lcd_sck_a;
            if (rises < 5) begin
               @(negedge clk);
               k++;
            end
         end
         check("abort_edge_timeout", rises, 5);
      end
      reset_a = 1'b1;
      @(negedge clk);
      reset_a = 1'b0;
      check_reset_pins_a("reset_mid_xfer");

      push(8, 16'h5500, 1'b1, 4, 1'b0);
      send(1'b0, 1'b0, 16'h0155);
      wait_idle(200);

      repeat (2) @(negedge clk);
      sel = 1'b1;
      @(negedge clk);
      push(8, 16'hA500, 1'b0, 1, 1'b0);
      send(1'b1, 1'b0, 16'h00A5);
      wait_idle(50);
      push(8, 16'h3C00, 1'b1, 1, 1'b0);
      send(1'b1, 1'b0, 16'h013C);
      wait_idle(50);
      repeat (2) @(negedge clk);
      check("b2b_total_edges", edges_b, 16);
      check("scoreboard_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
